dual_port_ram_be: RTL and testbench

- Parametrised true dual-port RAM, the next generation of the team's dual-port RAM.
- Adds per-byte write enables, registered reads with configurable latency and a read-valid strobe.
- Defines cross-port collision handling and read-during-write behaviour.
- Adds a hardware clear engine, so the processor/SPI datapath can zero the buffer without software loops.

---
 rtl/dual_port_ram_pkg.sv | 30 +++
 rtl/dual_port_ram_be_read_pipe.sv | 36 +++
 rtl/dual_port_ram_be.sv | 153 +++++++++++++++
 tb/tb_dual_port_ram_be.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// Types and helpers shared by the byte-enabled dual-port RAM and its read pipeline.
package dual_port_ram_pkg;

    typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_e;
    typedef enum logic {IDLE, CLEAR} clr_state_e;

    // byte_merge works on a fixed wide vector so every instance width can share it
    localparam int MERGE_MAX_W = 512;
    localparam int MERGE_IDX_W = 9;
    typedef logic [MERGE_MAX_W-1:0] merge_word_t;

    function automatic int lane_count(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic merge_word_t byte_merge(input merge_word_t old_w,
                                               input merge_word_t new_w,
                                               input merge_word_t be,
                                               input int          byte_w);
        merge_word_t            r;
        logic [MERGE_IDX_W-1:0] lane;
        r = old_w;
        for (int j = 0; j < MERGE_MAX_W; j++) begin
            lane = MERGE_IDX_W'(j / byte_w);
            if (be[lane]) r[j[MERGE_IDX_W-1:0]] = new_w[j[MERGE_IDX_W-1:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_port_ram_be_read_pipe.sv
// READ_LATENCY-deep read pipeline; the last stage holds its data between valid pulses.
module dpr_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  vld_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) dat_q[0] <= in_data;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[READ_LATENCY-1];
    assign out_data  = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, registered reads and a hardware clear engine.
// state | meaning
// IDLE  | ports serviced; clr starts a clear
// CLEAR | one word per cycle written with CLEAR_VALUE; ports dropped
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    DEPTH        = 1 << ADDR_WIDTH,
    parameter int                    READ_LATENCY = 1,
    parameter rdw_mode_e             RDW_MODE     = WRITE_FIRST,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            a_en,
    input  logic                                            a_we,
    input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0]   a_be,
    input  logic [ADDR_WIDTH-1:0]                           a_addr,
    input  logic [DATA_WIDTH-1:0]                           a_wdata,
    output logic [DATA_WIDTH-1:0]                           a_rdata,
    output logic                                            a_rvalid,
    input  logic                                            b_en,
    input  logic                                            b_we,
    input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0]   b_be,
    input  logic [ADDR_WIDTH-1:0]                           b_addr,
    input  logic [DATA_WIDTH-1:0]                           b_wdata,
    output logic [DATA_WIDTH-1:0]                           b_rdata,
    output logic                                            b_rvalid,
    input  logic                                            clr,
    output logic                                            busy,
    output logic                                            collision
);

    localparam int                  LANES     = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [LANES-1:0]      be);
        return DATA_WIDTH'(byte_merge(merge_word_t'(old_w), merge_word_t'(new_w),
                                      merge_word_t'(be), BYTE_WIDTH));
    endfunction

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  clr_wr, port_open;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_acc, b_acc, a_in, b_in, a_wr, b_wr, a_rd, b_rd, same_addr;
    logic [DATA_WIDTH-1:0] a_base, b_base, a_new, b_new, a_rd_word, b_rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr) state_d = CLEAR;
            CLEAR:   if (cnt_q == LAST_ADDR) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        clr_wr    = 1'b0;
        port_open = 1'b0;
        case (state_q)
            IDLE:  port_open = ~clr;
            CLEAR: begin
                busy   = 1'b1;
                clr_wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt_q <= '0;
        else if (state_q == IDLE)      cnt_q <= '0;
        else                           cnt_q <= cnt_q + ADDR_WIDTH'(1);
    end

    assign a_acc     = a_en & port_open & ~rst;
    assign b_acc     = b_en & port_open & ~rst;
    assign a_in      = in_range(a_addr);
    assign b_in      = in_range(b_addr);
    assign a_wr      = a_acc & a_we & a_in;
    assign b_wr      = b_acc & b_we & b_in;
    assign a_rd      = a_acc & ~a_we;
    assign b_rd      = b_acc & ~b_we;
    assign same_addr = (a_addr == b_addr);

    // On a shared write address, A's lanes are layered over B's merged word so A wins overlaps.
    always_comb begin
        a_base    = a_in ? mem[a_addr[IDX_W-1:0]] : '0;
        b_base    = b_in ? mem[b_addr[IDX_W-1:0]] : '0;
        b_new     = lane_merge(b_base, b_wdata, b_be);
        a_new     = lane_merge((b_wr && same_addr) ? b_new : a_base, a_wdata, a_be);
        a_rd_word = (RDW_MODE == WRITE_FIRST && b_wr && same_addr) ? b_new : a_base;
        b_rd_word = (RDW_MODE == WRITE_FIRST && a_wr && same_addr) ? a_new : b_base;
    end

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt_q[IDX_W-1:0]] <= CLEAR_VALUE;
        end else begin
            if (b_wr) mem[b_addr[IDX_W-1:0]] <= b_new;
            if (a_wr) mem[a_addr[IDX_W-1:0]] <= a_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) collision <= 1'b0;
        else     collision <= a_wr & b_wr & same_addr & (|(a_be & b_be));
    end

    dpr_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_rd),
        .in_data  (a_rd_word),
        .out_valid(a_rvalid),
        .out_data (a_rdata)
    );

    dpr_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_rd),
        .in_data  (b_rd_word),
        .out_valid(b_rvalid),
        .out_data (b_rdata)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: a write-first/latency-1 instance and a read-first/latency-2
// instance with one spare address bit share stimulus and are checked against a word-level model.
module tb_dual_port_ram_be;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_en, a_we, a_hi, b_en, b_we, b_hi, clr;
    logic [3:0]  a_be, b_be;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
    logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
    logic        busy0, busy1, coll0, coll1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_port_ram_be u_dut0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
        .clr(clr), .busy(busy0), .collision(coll0)
    );

    dual_port_ram_be #(
        .ADDR_WIDTH(9), .DEPTH(256), .READ_LATENCY(2),
        .RDW_MODE(dual_port_ram_pkg::READ_FIRST)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr({a_hi, a_addr}), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr({b_hi, b_addr}), .b_wdata(b_wdata),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .clr(clr), .busy(busy1), .collision(coll1)
    );

    // Model: per-instance memory with a known flag per word, clear progress, and a small
    // delivery calendar (slot = cycle mod 4) for read results; k = 2*instance + port.
    logic [31:0] mm [2][256];
    bit          mk [2][256];
    bit          busy_m;
    int          ci;
    int          cyc = 0;
    bit          sv [4][4];
    logic [31:0] sd [4][4];
    bit          sk [4][4];
    bit          e_rv [4];
    logic [31:0] e_rd [4];
    bit          e_rk [4];
    bit          e_coll [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        if (busy_m)
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 256; i++) mk[d][i] = 1'b0;
        busy_m = 1'b0;
        ci     = 0;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            e_rv[k] = 1'b0;
            e_rd[k] = 32'h0;
            e_rk[k] = 1'b1;
        end
        e_coll[0] = 1'b0;
        e_coll[1] = 1'b0;
    endtask

    task automatic schedule(input int k, input int lat, input logic [31:0] data, input bit known);
        int slot;
        slot = (cyc + lat - 1) % 4;
        sv[k][slot] = 1'b1;
        sd[k][slot] = data;
        sk[k][slot] = known;
    endtask

    task automatic model_edge();
        bit          acc, ain, bin, aw, bw, ka, kb;
        int          aa, ba, slot;
        logic [31:0] ra, rb, w;
        bit   [3:0]  wm;
        cyc++;
        if (rst) return;
        acc = !busy_m && !clr;
        e_coll[0] = 1'b0;
        e_coll[1] = 1'b0;
        if (busy_m) begin
            for (int d = 0; d < 2; d++) begin
                mm[d][ci] = 32'h0;
                mk[d][ci] = 1'b1;
            end
            ci++;
            if (ci == 256) busy_m = 1'b0;
        end else if (clr) begin
            busy_m = 1'b1;
            ci     = 0;
        end
        if (acc) begin
            for (int d = 0; d < 2; d++) begin
                aa  = (d == 0) ? int'(a_addr) : int'({a_hi, a_addr});
                ba  = (d == 0) ? int'(b_addr) : int'({b_hi, b_addr});
                ain = aa < 256;
                bin = ba < 256;
                aw  = a_en && a_we && ain;
                bw  = b_en && b_we && bin;
                ra  = ain ? mm[d][aa] : 32'h0;
                ka  = ain ? mk[d][aa] : 1'b1;
                rb  = bin ? mm[d][ba] : 32'h0;
                kb  = bin ? mk[d][ba] : 1'b1;
                e_coll[d] = aw && bw && (aa == ba) && ((a_be & b_be) != 4'h0);
                if (aw) begin
                    w  = mm[d][aa];
                    wm = 4'h0;
                    for (int l = 0; l < 4; l++) begin
                        if (a_be[l]) begin
                            w[8*l +: 8] = a_wdata[8*l +: 8];
                            wm[l] = 1'b1;
                        end else if (bw && ba == aa && b_be[l]) begin
                            w[8*l +: 8] = b_wdata[8*l +: 8];
                            wm[l] = 1'b1;
                        end
                    end
                    mm[d][aa] = w;
                    mk[d][aa] = mk[d][aa] || (wm == 4'hF);
                end
                if (bw && !(aw && ba == aa)) begin
                    w = mm[d][ba];
                    for (int l = 0; l < 4; l++)
                        if (b_be[l]) w[8*l +: 8] = b_wdata[8*l +: 8];
                    mm[d][ba] = w;
                    mk[d][ba] = mk[d][ba] || (b_be == 4'hF);
                end
                if (d == 0) begin
                    // write-first: a reader sees memory after this edge's writes
                    if (ain) begin ra = mm[d][aa]; ka = mk[d][aa]; end
                    if (bin) begin rb = mm[d][ba]; kb = mk[d][ba]; end
                end
                if (a_en && !a_we) schedule(2*d,   d + 1, ra, ka);
                if (b_en && !b_we) schedule(2*d+1, d + 1, rb, kb);
            end
        end
        slot = cyc % 4;
        for (int k = 0; k < 4; k++) begin
            e_rv[k] = sv[k][slot];
            if (sv[k][slot]) begin
                e_rd[k] = sd[k][slot];
                e_rk[k] = sk[k][slot];
                sv[k][slot] = 1'b0;
            end
        end
    endtask

    task automatic port_chk(input string nm, input logic rv, input logic [31:0] rd, input int k);
        check({nm, "_rvalid"}, 32'(rv), 32'(e_rv[k]));
        if (e_rk[k]) check({nm, "_rdata"}, rd, e_rd[k]);
    endtask

    always @(negedge clk) begin
        port_chk("a0", a_rvalid0, a_rdata0, 0);
        port_chk("b0", b_rvalid0, b_rdata0, 1);
        port_chk("a1", a_rvalid1, a_rdata1, 2);
        port_chk("b1", b_rvalid1, b_rdata1, 3);
        check("busy0", 32'(busy0), 32'(busy_m));
        check("busy1", 32'(busy1), 32'(busy_m));
        check("coll0", 32'(coll0), 32'(e_coll[0]));
        check("coll1", 32'(coll1), 32'(e_coll[1]));
    end

    task automatic idle();
        a_en = 0; a_we = 0; a_be = 4'h0; a_addr = 8'h0; a_wdata = 32'h0; a_hi = 0;
        b_en = 0; b_we = 0; b_be = 4'h0; b_addr = 8'h0; b_wdata = 32'h0; b_hi = 0;
        clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    task automatic acc_a(input logic we, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] d);
        a_en = 1; a_we = we; a_be = be; a_addr = addr; a_wdata = d;
    endtask

    task automatic acc_b(input logic we, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] d);
        b_en = 1; b_we = we; b_be = be; b_addr = addr; b_wdata = d;
    endtask

    task automatic rand_ports();
        a_en = $urandom_range(0, 3) != 0;  a_we = 1'($urandom);  a_be = 4'($urandom);
        a_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        a_wdata = $urandom;  a_hi = $urandom_range(0, 7) == 0;
        b_en = $urandom_range(0, 3) != 0;  b_we = 1'($urandom);  b_be = 4'($urandom);
        b_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        b_wdata = $urandom;  b_hi = $urandom_range(0, 7) == 0;
    endtask

    task automatic run_clear(input string nm, input bit poke);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        clr  = 1;
        step();
        while (busy0 && n < 400) begin
            n++;
            if (a_rvalid0 || b_rvalid0) seen = 1'b1;
            if (poke) begin
                rand_ports();
                clr = 1'($urandom);
            end
            step();
        end
        check(nm, 32'(n), 32'd256);
        if (poke) check({nm, "_no_rvalid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        #1 rst = 1;
        model_reset();
        #1;
        check("rst_a_rdata", a_rdata0, 32'h0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_coll", 32'(coll0), 32'd0);
        step(); step();
        rst = 0;

        run_clear("init_clear", 1'b1);

        // full write then cross-port read
        acc_a(1, 4'hF, 8'h10, 32'hDEADBEEF); step();
        acc_b(0, 4'hF, 8'h10, 32'h0); step();
        check("wr_rd_valid0", 32'(b_rvalid0), 32'd1);
        check("wr_rd_data0", b_rdata0, 32'hDEADBEEF);
        step();
        check("wr_rd_valid1", 32'(b_rvalid1), 32'd1);
        check("wr_rd_data1", b_rdata1, 32'hDEADBEEF);

        // partial byte-enable overwrite
        acc_a(1, 4'b0101, 8'h10, 32'h11223344); step();
        check("model_merge", mm[0][8'h10], 32'hDE22BE44);
        acc_a(0, 4'hF, 8'h10, 32'h0); step();
        check("merge_data0", a_rdata0, 32'hDE22BE44);
        step();
        check("merge_data1", a_rdata1, 32'hDE22BE44);

        // out-of-range on the 9-bit instance: write dropped, read returns zero
        acc_a(1, 4'hF, 8'h10, 32'h55555555); a_hi = 1; step();
        acc_b(0, 4'hF, 8'h10, 32'h0); step();
        check("oor_inrange_data0", b_rdata0, 32'h55555555);
        step();
        check("oor_dropped_data1", b_rdata1, 32'hDE22BE44);
        acc_a(0, 4'hF, 8'h10, 32'h0); a_hi = 1; step(); step();
        check("oor_read_valid1", 32'(a_rvalid1), 32'd1);
        check("oor_read_data1", a_rdata1, 32'h0);

        // read-during-write across ports
        acc_a(1, 4'hF, 8'h20, 32'hAAAAAAAA); acc_b(0, 4'hF, 8'h20, 32'h0); step();
        check("rdw_write_first", b_rdata0, 32'hAAAAAAAA);
        step();
        check("rdw_read_first_valid", 32'(b_rvalid1), 32'd1);
        check("rdw_read_first", b_rdata1, 32'h0);

        // write/write overlap
        acc_a(1, 4'b0011, 8'h30, 32'h000000FF); acc_b(1, 4'b1110, 8'h30, 32'hFFFF0000); step();
        check("coll_pulse", 32'(coll0), 32'd1);
        check("model_ww", mm[0][8'h30], 32'hFFFF00FF);
        acc_b(0, 4'hF, 8'h30, 32'h0); step();
        check("coll_one_cycle", 32'(coll0), 32'd0);
        check("ww_data0", b_rdata0, 32'hFFFF00FF);

        // disjoint lanes at the same address: no collision
        acc_a(1, 4'b0011, 8'h31, 32'h12345678); acc_b(1, 4'b1100, 8'h31, 32'h9ABCDEF0); step();
        check("no_coll_disjoint", 32'(coll0), 32'd0);
        check("model_disjoint", mm[0][8'h31], 32'h9ABC5678);

        for (int i = 0; i < 3000; i++) begin
            rand_ports();
            clr = $urandom_range(0, 499) == 0;
            step();
        end
        while (busy_m) step();

        for (int i = 0; i < 256; i++) begin
            acc_a(1, 4'hF, 8'(i), $urandom | 32'h1);
            step();
        end
        run_clear("fill_clear", 1'b1);
        acc_a(0, 4'hF, 8'h00, 32'h0); acc_b(0, 4'hF, 8'h7F, 32'h0); step();
        check("cleared_00_valid", 32'(a_rvalid0), 32'd1);
        check("cleared_00", a_rdata0, 32'h0);
        check("cleared_7f", b_rdata0, 32'h0);
        acc_a(0, 4'hF, 8'hFF, 32'h0); step();
        check("cleared_ff", a_rdata0, 32'h0);
        step();

        // reset in the middle of a clear
        acc_a(1, 4'hF, 8'h40, 32'hCAFEF00D); step();
        clr = 1; step();
        repeat (49) step();
        check("mid_clear_busy", 32'(busy0), 32'd1);
        rst = 1;
        model_reset();
        #1;
        check("rst_mid_busy", 32'(busy0), 32'd0);
        check("rst_mid_rvalid", 32'(a_rvalid0), 32'd0);
        step(); step();
        rst = 0;
        acc_a(0, 4'hF, 8'h05, 32'h0); step();
        check("post_rst_rvalid", 32'(a_rvalid0), 32'd1);
        step();
        run_clear("restart_clear", 1'b0);
        acc_a(0, 4'hF, 8'h05, 32'h0); acc_b(0, 4'hF, 8'hC8, 32'h0); step();
        check("restart_05", a_rdata0, 32'h0);
        check("restart_c8_valid", 32'(b_rvalid0), 32'd1);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
